// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, debouncer, press/release/long-press strobes
// and a wrap-around press counter. All outputs are registered.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned LONG_CYCLES     = 25000000,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_in,
  output logic             btn_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic [CNT_W-1:0] press_count
);

  localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HoldW = $clog2(LONG_CYCLES);
  localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [DebW-1:0]  cnt_q, cnt_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             long_done_q, long_done_d;
  logic             level_q, level_d;
  logic             press_q, release_q, long_q, long_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             p, rise, fall;

  assign p = sync2_q ^ ACTIVE_LOW;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (p == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DebLast) begin
      level_d = p;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + DebW'(1);
    end
  end

  assign rise    = level_d & ~level_q;
  assign fall    = ~level_d & level_q;
  assign count_d = count_q + CNT_W'(rise);

  // A release on the terminal-count edge wins: fall is checked before the long test.
  always_comb begin
    hold_d      = hold_q;
    long_done_d = long_done_q;
    long_d      = 1'b0;
    if (rise || fall) begin
      hold_d      = '0;
      long_done_d = 1'b0;
    end else if (level_q && !long_done_q) begin
      if (hold_q == HoldLast) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end else begin
        hold_d = hold_q + HoldW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= ACTIVE_LOW;
      sync2_q     <= ACTIVE_LOW;
      cnt_q       <= '0;
      hold_q      <= '0;
      long_done_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      sync1_q     <= btn_in;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= rise;
      release_q   <= fall;
      long_q      <= long_d;
      count_q     <= count_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: vector table, directed corner sequences and random pad
// activity, all checked against an edge-indexed history model.
module tb_button_conditioner;

  localparam int unsigned D = 8;
  localparam int unsigned L = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_in = 1'b1;
  logic       btn_level, press_pulse, release_pulse, long_pulse;
  logic [7:0] press_count;

  int vectors = 0;
  int miscompares = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .ACTIVE_LOW     (1'b1),
    .CNT_W          (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  always #5 clk = ~clk;

  // Model: every sampled pad value since reset, indexed by edge number.
  bit         pads[$];
  bit         level_m;
  int         last_change, press_edge;
  logic [7:0] count_m;
  bit         e_press, e_release, e_long;

  function automatic bit p_at(int k);
    return (k >= 2) ? !pads[k-2] : 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pads.delete();
    level_m     = 1'b0;
    last_change = -1;
    press_edge  = -1;
    count_m     = 8'd0;
    e_press     = 1'b0;
    e_release   = 1'b0;
    e_long      = 1'b0;
  endtask

  // Level flips at edge n when the last D evaluated levels all disagree with it and
  // at least D edges have passed since the previous flip.
  task automatic model_edge();
    int n;
    bit fire;
    pads.push_back(btn_in);
    n = pads.size() - 1;
    fire = (n - last_change >= int'(D));
    for (int k = 0; k < int'(D); k++)
      if (n - k < 0 || p_at(n - k) == level_m) fire = 1'b0;
    e_press   = fire && !level_m;
    e_release = fire && level_m;
    e_long    = level_m && !fire && press_edge >= 0 && (n - press_edge == int'(L));
    if (fire) begin
      level_m     = !level_m;
      last_change = n;
      if (e_press) begin
        count_m    = count_m + 8'd1;
        press_edge = n;
      end else begin
        press_edge = -1;
      end
    end
  endtask

  task automatic step(input bit pad);
    btn_in = pad;
    @(posedge clk);
    model_edge();
    #1;
    check("outputs", {btn_level, press_pulse, release_pulse, long_pulse, press_count},
          {level_m, e_press, e_release, e_long, count_m});
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset", {btn_level, press_pulse, release_pulse, long_pulse, press_count},
          32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Steps with the pad pressed until press_pulse, returning its 0-based edge index.
  task automatic measure_press(output int idx);
    idx = -1;
    for (int i = 0; i < 30 && idx < 0; i++) begin
      step(1'b0);
      if (press_pulse) idx = i;
    end
  endtask

  typedef struct {
    bit          pad;
    int unsigned cycles;
    bit          exp_level;
    logic [7:0]  exp_count;
  } vec_t;

  vec_t vtab[10];

  initial begin
    int idx, first, longs, rels;

    vtab[0] = '{1'b1, 5,  1'b0, 8'd0};
    vtab[1] = '{1'b0, 12, 1'b1, 8'd1};
    vtab[2] = '{1'b1, 12, 1'b0, 8'd1};
    vtab[3] = '{1'b0, 5,  1'b0, 8'd1};
    vtab[4] = '{1'b1, 2,  1'b0, 8'd1};
    vtab[5] = '{1'b0, 5,  1'b0, 8'd1};
    vtab[6] = '{1'b0, 5,  1'b1, 8'd2};
    vtab[7] = '{1'b1, 12, 1'b0, 8'd2};
    vtab[8] = '{1'b0, 50, 1'b1, 8'd3};
    vtab[9] = '{1'b1, 12, 1'b0, 8'd3};

    model_reset();
    #1;
    check("reset_state", {btn_level, press_pulse, release_pulse, long_pulse, press_count},
          32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vtab[i]) begin
      for (int c = 0; c < int'(vtab[i].cycles); c++) step(vtab[i].pad);
      check($sformatf("table_%0d", i), {btn_level, press_count},
            {vtab[i].exp_level, vtab[i].exp_count});
    end

    // Clean press: accepted on edge 9 counting the first sampling edge as 0.
    measure_press(idx);
    check("clean_press_edge", idx, 9);
    check("clean_press_count", press_count, 8'd4);
    step(1'b0);
    check("press_one_cycle", press_pulse, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1);

    // Bounce: low 5, high 2, then stable low from the final falling sample.
    for (int i = 0; i < 5; i++) step(1'b0);
    for (int i = 0; i < 2; i++) step(1'b1);
    measure_press(idx);
    check("bounce_press_edge", idx, 9);

    // Long press: one long_pulse 32 edges after the press edge, none after.
    first = -1;
    longs = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0);
      if (long_pulse) begin
        longs++;
        if (first < 0) first = i;
      end
    end
    check("long_edge", first, 32);
    check("long_count", longs, 1);
    rels = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1);
      if (release_pulse) rels++;
    end
    check("long_release", rels, 1);

    // Short press: no long_pulse.
    measure_press(idx);
    longs = 0;
    rels = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0);
      if (long_pulse) longs++;
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1);
      if (release_pulse) rels++;
      if (long_pulse) longs++;
    end
    check("short_press_edge", idx, 9);
    check("short_no_long", longs, 0);
    check("short_release", rels, 1);

    // Wrap of the 8-bit press counter.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      for (int c = 0; c < 12; c++) step(1'b0);
      for (int c = 0; c < 12; c++) step(1'b1);
    end
    check("wrap_256", press_count, 8'd0);
    for (int c = 0; c < 12; c++) step(1'b0);
    check("wrap_257", press_count, 8'd1);
    for (int c = 0; c < 12; c++) step(1'b1);

    // Reset mid-hold with the button kept pressed.
    measure_press(idx);
    for (int i = 0; i < 20; i++) step(1'b0);
    do_reset();
    measure_press(idx);
    check("reset_hold_press_edge", idx + 1, 10);
    check("reset_hold_count", press_count, 8'd1);
    first = -1;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0);
      if (long_pulse && first < 0) first = i;
    end
    check("reset_hold_long_edge", first, 32);
    for (int i = 0; i < 12; i++) step(1'b1);

    // Random pad activity, including long holds and an occasional reset.
    for (int s = 0; s < 300; s++) begin
      bit pad;
      int len;
      pad = 1'($urandom_range(0, 1));
      len = ($urandom % 4 == 0) ? int'($urandom_range(30, 45)) : int'($urandom_range(1, 11));
      for (int c = 0; c < len; c++) step(pad);
      if (s % 97 == 50) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Conditions the raw board push-button (open-drain, active-low pad, 25 MHz domain) into clean control events for the LED blink/PWM stage. It synchronises the pad, debounces it, and produces a level plus single-cycle press, release and long-press strobes. It also keeps a wrap-around press counter that the downstream LED stage uses for mode selection.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a new level (10 ms @ 25 MHz); legal range ≥2.
LONG_CYCLES, 25000000, cycles held pressed before long_pulse fires (1 s @ 25 MHz); must be > 1.
ACTIVE_LOW, 1, 1 = pad reads 0 when pressed; 0 = pad reads 1 when pressed.
CNT_W, 8, width of press_count.

Ports:
clk  input  1  system clock, 25 MHz
rst_n  input  1  reset, asynchronous assert, active-low
btn_in  input  1  raw, asynchronous button pad
btn_level  output  1  debounced level, 1 = pressed (polarity-normalised)
press_pulse  output  1  one-cycle strobe on accepted press
release_pulse  output  1  one-cycle strobe on accepted release
long_pulse  output  1  one-cycle strobe when hold reaches LONG_CYCLES
press_count  output  CNT_W  number of accepted presses, modulo 2^CNT_W

Behaviour:
- Reset (rst_n=0, async): both sync flops load the released pad value (ACTIVE_LOW ? 1 : 0). Debounce counter and hold counter are 0. btn_level, press_pulse, release_pulse and long_pulse are 0. press_count is 0. All outputs are registered.
- Sync: 2-flop synchroniser, sync1 <= btn_in and sync2 <= sync1. Normalise: p = sync2 XOR ACTIVE_LOW.
- Debounce, evaluated each edge:
  - If p == btn_level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: btn_level <= p and cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency: call edge 0 the first edge that samples a new pad value. btn_level changes at edge DEBOUNCE_CYCLES+1, provided the pad stays stable.
- Glitch rejection: any mismatch run shorter than DEBOUNCE_CYCLES clears cnt, and btn_level does not change.
- Strobes fire on the same edge that btn_level changes:
  - press_pulse=1 on a 0→1 change; press_count increments on that edge and wraps 2^CNT_W-1 → 0.
  - release_pulse=1 on a 1→0 change.
  - Each strobe is high for exactly 1 cycle.
- Long press:
  - hold counter is cleared on the edge btn_level rises.
  - It increments every cycle while btn_level=1.
  - When hold == LONG_CYCLES-1 and btn_level=1: long_pulse=1 for one cycle, then hold saturates and no repeat occurs.
  - Release clears hold and re-arms long_pulse.
  - Release before LONG_CYCLES gives no long_pulse.
- Simultaneous events: press and release strobes are mutually exclusive by construction. long_pulse never coincides with release_pulse; if the release is accepted on the same edge as the terminal count, the release wins and long_pulse is suppressed.
- Reset mid-operation: async clear to the reset state above. If the button is held through reset deassert, it is debounced normally and produces press_pulse DEBOUNCE_CYCLES+2 edges after deassert, with press_count=1.
- Counter widths: debounce counter is $clog2(DEBOUNCE_CYCLES); hold counter is $clog2(LONG_CYCLES). Neither overflows.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=8, LONG_CYCLES=32, ACTIVE_LOW=1.
1. Clean press: btn_in 1→0 held. btn_level=1 and press_pulse=1 (1 cycle) at edge 9 after first sampling edge; press_count 0→1.
2. Bounce: btn_in toggles low 5 cycles, high 2, low 5. No btn_level change. Then a stable low gives btn_level=1 exactly 9 edges after the final falling sample.
3. Long press: hold pressed 40 cycles after btn_level=1. long_pulse fires once, 32 cycles after the press edge; no second pulse. Release gives release_pulse once.
4. Short press: held 20 cycles then released. press_pulse and release_pulse each once; long_pulse never asserted.
5. Wrap: 256 accepted presses. press_count returns to 0; 257th press gives 1.
6. Reset mid-hold: assert rst_n=0 while btn_level=1 and hold=20. All outputs 0 immediately (async). With button still held, deassert: press_pulse 10 edges later, no long_pulse until a further 32 cycles.
